// File: rtl/mbisr_repair_alloc_if.sv
// mbisr_repair_alloc_if: MBIST fail stream, functional lookup and repair status bundle
interface mbisr_repair_alloc_if #(
  parameter int ADDR_W = 4,
  parameter int IDX_W  = 3
);
  logic              start_i;
  logic              fail_valid_i;
  logic [ADDR_W-1:0] fail_addr_i;
  logic              fail_ready_o;
  logic              bist_done_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              remap_hit_o;
  logic [IDX_W-1:0]  remap_idx_o;
  logic [IDX_W:0]    spares_used_o;
  logic              repair_done_o;
  logic              repair_fail_o;
  logic [7:0]        fail_count_o;
  modport master (
    output start_i, fail_valid_i, fail_addr_i, bist_done_i, mem_addr_i,
    input  fail_ready_o, remap_hit_o, remap_idx_o, spares_used_o,
           repair_done_o, repair_fail_o, fail_count_o
  );
  modport slave (
    input  start_i, fail_valid_i, fail_addr_i, bist_done_i, mem_addr_i,
    output fail_ready_o, remap_hit_o, remap_idx_o, spares_used_o,
           repair_done_o, repair_fail_o, fail_count_o
  );
endinterface

// File: rtl/mbisr_repair_alloc.sv
// mbisr_repair_alloc: allocates MBIST failing addresses to spare words and remaps lookups (MBISR_FAIL_COUNT_EN adds fail counter; ports: clk, rst, bus slave)
module mbisr_repair_alloc #(
  parameter int ADDR_W     = 4,
  parameter int NUM_SPARES = 2,
  parameter int IDX_W      = 3
) (
  input logic clk,
  input logic rst,
  mbisr_repair_alloc_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, ALLOC, DONE, FAIL} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] entry [NUM_SPARES];
  logic [NUM_SPARES-1:0] valid;
  logic [IDX_W:0] used;
  logic match, hit, full, xfer;
  logic [IDX_W-1:0] idx;
  assign xfer = bus.fail_valid_i && bus.fail_ready_o;
  assign full = used >= (IDX_W+1)'(NUM_SPARES);
  assign bus.spares_used_o = used;
  // descending scan so the lowest matching entry wins the lookup
  always_comb begin
    match = 1'b0;
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (valid[i] && entry[i] == cur_addr) match = 1'b1;
      if (valid[i] && entry[i] == bus.mem_addr_i) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
  always_comb begin
    state_nx = state;
    bus.fail_ready_o = 1'b0;
    bus.repair_done_o = 1'b0;
    bus.repair_fail_o = 1'b0;
    bus.fail_ready_o = state == COLLECT;
    bus.repair_done_o = state == DONE;
    bus.repair_fail_o = state == FAIL;
    state_nx = bus.start_i      ? COLLECT :
               state == COLLECT ? (bus.fail_valid_i ? CHECK : bus.bist_done_i ? DONE : COLLECT) :
               state == CHECK   ? (match ? COLLECT : full ? FAIL : ALLOC) :
               state == ALLOC   ? COLLECT : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      used <= '0;
      cur_addr <= '0;
      bus.remap_hit_o <= 1'b0;
      bus.remap_idx_o <= '0;
      for (int i = 0; i < NUM_SPARES; i++) entry[i] <= '0;
    end else begin
      state <= state_nx;
      bus.remap_hit_o <= state == DONE && !bus.start_i && hit;
      bus.remap_idx_o <= (state == DONE && !bus.start_i && hit) ? idx : '0;
      if (xfer && !bus.start_i) cur_addr <= bus.fail_addr_i;
      if (bus.start_i) begin
        valid <= '0;
        used <= '0;
      end else if (state == ALLOC) begin
        used <= used + 1'b1;
        for (int i = 0; i < NUM_SPARES; i++)
          if (used == (IDX_W+1)'(i)) begin
            valid[i] <= 1'b1;
            entry[i] <= cur_addr;
          end
      end
    end
  end
`ifdef MBISR_FAIL_COUNT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || bus.start_i) cnt <= '0;
    else if (xfer && cnt != 8'hff) cnt <= cnt + 1'b1;
  end
  assign bus.fail_count_o = cnt;
`else
  assign bus.fail_count_o = 8'h00;
`endif
endmodule

// File: tb/tb_mbisr_repair_alloc.sv
// tb_mbisr_repair_alloc: scoreboard bench for the spare allocator
module tb_mbisr_repair_alloc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mbisr_repair_alloc_if #(.ADDR_W(4), .IDX_W(3)) ifc ();
  mbisr_repair_alloc #(.ADDR_W(4), .NUM_SPARES(2), .IDX_W(3)) dut (.clk(clk), .rst(rst), .bus(ifc));
`ifdef MBISR_FAIL_COUNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0]  acc_q  [$];
  logic [13:0] stat_q [$];
  logic [3:0]  look_q [$];
  logic [18:0] snap_q [$];
  logic look_req = 1'b0, look_pend = 1'b0, snap_req = 1'b0, pd = 1'b0, pf = 1'b0;
  function automatic logic [7:0] cnt(input int n);
    return CE ? 8'(n) : 8'h00;
  endfunction
  always @(negedge clk) begin
    logic [13:0] es;
    logic [3:0] el;
    logic [18:0] en, an;
    if (!rst) begin
      if (ifc.fail_valid_i && ifc.fail_ready_o) begin
        n_chk++;
        if (acc_q.size() == 0) begin
          n_fail++;
          $display("FAIL accept: unexpected transfer of addr %h, required none", ifc.fail_addr_i);
        end else begin
          el = acc_q.pop_front();
          if (ifc.fail_addr_i !== el) begin
            n_fail++;
            $display("FAIL accept: addr %h, required %h", ifc.fail_addr_i, el);
          end
        end
      end
      if ((ifc.repair_done_o || ifc.repair_fail_o) && !(pd || pf)) begin
        n_chk++;
        es = {ifc.repair_done_o, ifc.repair_fail_o, ifc.spares_used_o, ifc.fail_count_o};
        if (stat_q.size() == 0) begin
          n_fail++;
          $display("FAIL status: unexpected result %h", es);
        end else begin
          el = 4'h0;
          if (es !== stat_q[0]) begin
            n_fail++;
            $display("FAIL status: {done,fail,used,count}=%h, required %h", es, stat_q[0]);
          end
          void'(stat_q.pop_front());
        end
      end
      pd = ifc.repair_done_o;
      pf = ifc.repair_fail_o;
      if (look_pend) begin
        n_chk++;
        el = look_q.pop_front();
        if ({ifc.remap_hit_o, ifc.remap_idx_o} !== el) begin
          n_fail++;
          $display("FAIL lookup: {hit,idx}=%h, required %h", {ifc.remap_hit_o, ifc.remap_idx_o}, el);
        end
      end
      look_pend = look_req;
      if (snap_req) begin
        n_chk++;
        en = snap_q.pop_front();
        an = {ifc.fail_ready_o, ifc.repair_done_o, ifc.repair_fail_o, ifc.spares_used_o,
              ifc.remap_hit_o, ifc.remap_idx_o, ifc.fail_count_o};
        if (an !== en) begin
          n_fail++;
          $display("FAIL snapshot: {ready,done,fail,used,hit,idx,count}=%h, required %h", an, en);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    ifc.start_i = 1'b1;
    ifc.bist_done_i = 1'b0;
    tick();
    ifc.start_i = 1'b0;
  endtask
  task automatic snap(input logic [18:0] e);
    snap_q.push_back(e);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask
  task automatic lookup(input logic [3:0] a, input logic [3:0] e);
    ifc.mem_addr_i = a;
    look_q.push_back(e);
    look_req = 1'b1;
    tick();
    look_req = 1'b0;
  endtask
  task automatic send(input logic [3:0] a, input logic bd);
    bit ok = 1'b0;
    acc_q.push_back(a);
    ifc.fail_valid_i = 1'b1;
    ifc.fail_addr_i = a;
    if (bd) ifc.bist_done_i = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = ifc.fail_ready_o;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: ready=0 after 20 cycles, required 1 (addr %h)", a);
    end
    tick();
    ifc.fail_valid_i = 1'b0;
  endtask
  task automatic wait_flag(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < n && !ok; k++) begin
      @(negedge clk);
      ok = ifc.repair_done_o || ifc.repair_fail_o;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL result_timeout: no done/fail within %0d cycles, required one", n);
    end
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    ifc.start_i = 1'b0;
    ifc.fail_valid_i = 1'b0;
    ifc.fail_addr_i = 4'h0;
    ifc.bist_done_i = 1'b0;
    ifc.mem_addr_i = 4'h0;
    repeat (3) tick();
    rst = 1'b0;
    snap({1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0});
    stat_q.push_back({1'b1, 1'b0, 4'd0, 8'd0});
    pulse_start();
    ifc.bist_done_i = 1'b1;
    wait_flag(2);
    pulse_start();
    send(4'h3, 1'b0);
    send(4'hA, 1'b0);
    stat_q.push_back({1'b1, 1'b0, 4'd2, cnt(2)});
    ifc.bist_done_i = 1'b1;
    wait_flag(5);
    lookup(4'hA, {1'b1, 3'd1});
    lookup(4'h5, {1'b0, 3'd0});
    lookup(4'h3, {1'b1, 3'd0});
    tick();
    pulse_start();
    send(4'h3, 1'b0);
    send(4'h3, 1'b0);
    send(4'h3, 1'b0);
    stat_q.push_back({1'b1, 1'b0, 4'd1, cnt(3)});
    ifc.bist_done_i = 1'b1;
    wait_flag(5);
    pulse_start();
    stat_q.push_back({1'b0, 1'b1, 4'd2, cnt(3)});
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h7, 1'b0);
    wait_flag(2);
    ifc.fail_valid_i = 1'b1;
    ifc.fail_addr_i = 4'h9;
    repeat (4) tick();
    ifc.fail_valid_i = 1'b0;
    snap({1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 3'd0, cnt(3)});
    pulse_start();
    snap({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0});
    repeat (3) acc_q.push_back(4'h4);
    ifc.fail_valid_i = 1'b1;
    ifc.fail_addr_i = 4'h4;
    repeat (6) tick();
    ifc.fail_valid_i = 1'b0;
    stat_q.push_back({1'b1, 1'b0, 4'd2, cnt(4)});
    send(4'hB, 1'b1);
    wait_flag(8);
    lookup(4'hB, {1'b1, 3'd1});
    lookup(4'h4, {1'b1, 3'd0});
    lookup(4'h9, {1'b0, 3'd0});
    pulse_start();
    snap({1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0});
    tick();
    n_chk++;
    if (acc_q.size() + stat_q.size() + look_q.size() + snap_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0",
               acc_q.size() + stat_q.size() + look_q.size() + snap_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
